// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// No logic; op codes, FSM states and counter sizing only.
// Backpressure: n/a.
package mul_div_unit_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIN  = 2'd2
    } md_state_e;

    function automatic int md_cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Turns magnitude product / quotient+remainder into signed HI/LO.
// Latency: combinational. Backpressure: none.
// Sign flags are only ever set for signed ops, so unsigned results pass through.
module md_sign_fix #(
    parameter int size = 32
) (
    input  logic            is_div,
    input  logic            neg_a,
    input  logic            neg_b,
    input  logic [size-1:0] mag_hi,
    input  logic [size-1:0] mag_lo,
    output logic [size-1:0] hi,
    output logic [size-1:0] lo
);

    logic [2*size-1:0] prod_neg;

    assign prod_neg = -{mag_hi, mag_lo};

    always_comb begin
        hi = mag_hi;
        lo = mag_lo;
        if (!is_div) begin
            if (neg_a ^ neg_b) {hi, lo} = prod_neg;
        end else begin
            // quotient truncates toward zero, remainder follows the dividend
            if (neg_a ^ neg_b) lo = -mag_lo;
            if (neg_a)         hi = -mag_hi;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide producing HI/LO, one bit per cycle.
// Latency: size+1 cycles from accepted start to done_o.
// Backpressure: start_i ignored while busy_o; abort_i cancels silently.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [1:0]      op_i,
    input  logic [size-1:0] src1_i,
    input  logic [size-1:0] src2_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [size-1:0] hi_o,
    output logic [size-1:0] lo_o
);

    localparam int CW = md_cnt_w(size);

    md_state_e       state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            is_div, neg_a, neg_b;
    logic [size-1:0] acc, qm, opb;
    logic [size-1:0] hi_q, lo_q, fix_hi, fix_lo;
    logic            done_q;

    logic            div_zero, a_neg_in, b_neg_in;
    logic [size-1:0] mag_a, mag_b;
    logic [size:0]   add_sum, mul_s, shl, diff;

    // A zero divisor runs the raw dividend unsigned: the restoring loop then
    // yields all-ones quotient and the untouched dividend as remainder.
    assign div_zero = op_i[1] && (src2_i == '0);
    assign a_neg_in = op_i[0] && src1_i[size-1] && !div_zero;
    assign b_neg_in = op_i[0] && src2_i[size-1];
    assign mag_a    = a_neg_in ? -src1_i : src1_i;
    assign mag_b    = b_neg_in ? -src2_i : src2_i;

    assign add_sum = {1'b0, acc} + {1'b0, opb};
    assign mul_s   = qm[0] ? add_sum : {1'b0, acc};
    assign shl     = {acc, qm[size-1]};
    assign diff    = shl - {1'b0, opb};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= MD_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MD_IDLE: if (start_i && !abort_i) state_nxt = MD_RUN;
            MD_RUN: begin
                if (abort_i)              state_nxt = MD_IDLE;
                else if (cnt == CW'(1))   state_nxt = MD_FIN;
            end
            MD_FIN:  state_nxt = MD_IDLE;
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt    <= '0;
            is_div <= 1'b0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            acc    <= '0;
            qm     <= '0;
            opb    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (start_i && !abort_i) begin
                        is_div <= op_i[1];
                        neg_a  <= a_neg_in;
                        neg_b  <= b_neg_in;
                        acc    <= '0;
                        cnt    <= CW'(size);
                        qm     <= op_i[1] ? mag_a : mag_b;
                        opb    <= op_i[1] ? mag_b : mag_a;
                    end
                end
                MD_RUN: begin
                    if (!abort_i) begin
                        cnt <= cnt - CW'(1);
                        if (is_div) begin
                            // restoring step; diff's top bit is the borrow
                            if (!diff[size]) begin
                                acc <= diff[size-1:0];
                                qm  <= {qm[size-2:0], 1'b1};
                            end else begin
                                acc <= shl[size-1:0];
                                qm  <= {qm[size-2:0], 1'b0};
                            end
                        end else begin
                            acc <= mul_s[size:1];
                            qm  <= {mul_s[0], qm[size-1:1]};
                        end
                    end
                end
                MD_FIN: begin
                    if (!abort_i) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    md_sign_fix #(.size(size)) u_sign_fix (
        .is_div (is_div),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .mag_hi (acc),
        .mag_lo (qm),
        .hi     (fix_hi),
        .lo     (fix_lo)
    );

    assign busy_o = (state != MD_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: arithmetic, latency, start/abort/reset corners.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic        clk, rst, start, abort;
    logic [1:0]  op;
    logic [31:0] src1, src2;
    logic        busy, done;
    logic [31:0] hi, lo;

    int passed = 0;
    int total  = 0;
    int lat, busy_bad;

    mul_div_unit #(.size(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .abort_i (abort),
        .op_i    (op),
        .src1_i  (src1),
        .src2_i  (src2),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called on a negedge; returns edge count after start edge at which done was seen (0 = never).
    task automatic wait_done(output int l, output int bb);
        l  = 0;
        bb = 0;
        for (int k = 1; k <= 40 && l == 0; k++) begin
            @(negedge clk);
            if (done) l = k;
            else if (!busy) bb++;
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int l, output int bb);
        op = o; src1 = a; src2 = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(l, bb);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0; op = MD_MULTU; src1 = '0; src2 = '0;
        #1 rst = 1'b1;
        #11;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: MULTU max*max, latency and busy
        do_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_bad);
        check("t1_latency", lat, 33);
        check("t1_busy_gaps", busy_bad, 0);
        check("t1_busy_at_done", {31'd0, busy}, 32'd0);
        check("t1_hi", hi, 32'hFFFFFFFE);
        check("t1_lo", lo, 32'h00000001);
        @(negedge clk);
        check("t1_done_one_cycle", {31'd0, done}, 32'd0);

        // 2: signed multiply
        do_op(MD_MULT, 32'hFFFFFFFD, 32'd7, lat, busy_bad);
        check("t2a_hi", hi, 32'hFFFFFFFF);
        check("t2a_lo", lo, 32'hFFFFFFEB);
        do_op(MD_MULT, 32'h80000000, 32'd2, lat, busy_bad);
        check("t2b_hi", hi, 32'hFFFFFFFF);
        check("t2b_lo", lo, 32'h00000000);

        // 3: divide
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd2, lat, busy_bad);
        check("t3a_lo", lo, 32'hFFFFFFFD);
        check("t3a_hi", hi, 32'hFFFFFFFF);
        do_op(MD_DIVU, 32'd100, 32'd7, lat, busy_bad);
        check("t3b_lo", lo, 32'd14);
        check("t3b_hi", hi, 32'd2);
        do_op(MD_DIVU, 32'd100, 32'd0, lat, busy_bad);
        check("t3c_latency", lat, 33);
        check("t3c_lo", lo, 32'hFFFFFFFF);
        check("t3c_hi", hi, 32'h00000064);
        do_op(MD_DIV, 32'hFFFFFFF9, 32'd0, lat, busy_bad);
        check("t3d_lo", lo, 32'hFFFFFFFF);
        check("t3d_hi", hi, 32'hFFFFFFF9);
        do_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busy_bad);
        check("t3e_lo", lo, 32'h80000000);
        check("t3e_hi", hi, 32'h00000000);

        // 4: start while busy ignored; start on done cycle accepted
        op = MD_MULTU; src1 = 32'd5; src2 = 32'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) lat = k;
            if (k == 10) begin
                start = 1'b1; op = MD_DIVU; src1 = 32'd9; src2 = 32'd9;
            end
        end
        start = 1'b0;
        check("t4_latency", lat, 33);
        check("t4_hi", hi, 32'd0);
        check("t4_lo", lo, 32'd30);
        do_op(MD_MULTU, 32'd2, 32'd3, lat, busy_bad);
        check("t4_b2b_latency", lat, 33);
        check("t4_b2b_lo", lo, 32'd6);
        op = MD_MULTU; src1 = 32'd7; src2 = 32'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_start_on_done_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, busy_bad);
        check("t4_start_on_done_lo", lo, 32'd56);

        // 5: abort mid-divide keeps old HI/LO
        do_op(MD_DIVU, 32'd5, 32'd2, lat, busy_bad);
        check("t5_pre_hi", hi, 32'd1);
        check("t5_pre_lo", lo, 32'd2);
        op = MD_DIVU; src1 = 32'd100; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t5_abort_busy", {31'd0, busy}, 32'd0);
        check("t5_abort_done", {31'd0, done}, 32'd0);
        wait_done(lat, busy_bad);
        check("t5_no_done", lat, 0);
        check("t5_hi", hi, 32'd1);
        check("t5_lo", lo, 32'd2);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("t5_idle_abort_wins", {31'd0, busy}, 32'd0);

        // 6: async reset mid-operation
        op = MD_MULT; src1 = 32'hFFFFFFFD; src2 = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_done", {31'd0, done}, 32'd0);
        check("t6_hi", hi, 32'd0);
        check("t6_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_op(MD_MULTU, 32'd3, 32'd4, lat, busy_bad);
        check("t6_after_lo", lo, 32'd12);
        check("t6_after_hi", hi, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative 32-cycle multiply/divide unit for the single-cycle/pipelined MIPS datapath.
- Consumes rs/rt operands at EX and produces the HI/LO register pair.
- HI/LO feed the writeback-select 2-to-1 muxes (ALU result vs HI/LO) directly downstream.
- Handshake is start/busy/done. The control unit stalls the pipeline while busy_o is high.

Parameters:
- size, 32, operand width in bits. HI and LO are each size bits. Iteration count equals size.

Ports:
- clk_i  input  1  clock. All state changes on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request a new operation. Sampled only in IDLE.
- abort_i  input  1  pipeline flush. Cancels an in-flight operation.
- op_i  input  2  operation: 00 MULTU, 01 MULT (signed), 10 DIVU, 11 DIV (signed).
- src1_i  input  size  rs operand: multiplicand or dividend.
- src2_i  input  size  rt operand: multiplier or divisor.
- busy_o  output  1  operation in progress.
- done_o  output  1  one-cycle pulse; HI/LO hold the new result.
- hi_o  output  size  HI register: product upper half or remainder.
- lo_o  output  size  LO register: product lower half or quotient.

Behaviour:
Reset:
- rst_i asserted at any time, including mid-operation, forces state IDLE on the spot.
- Clears hi_o, lo_o, done_o, busy_o, the iteration counter and the working registers to 0.

States (state encoding in the shared package):
- IDLE -> RUN on the edge with start_i=1.
  - Latch op_i and the operand magnitudes. For signed ops, take the absolute value; the sign bits are recorded.
  - Load counter = size.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle.
  - The counter decrements each cycle.
  - Moves to FIN on the edge where the counter goes 1 -> 0, i.e. after exactly size RUN cycles.
- FIN -> IDLE on the next edge.
  - Apply sign correction and write hi_o/lo_o.
  - done_o=1 for exactly the following cycle.
- busy_o = (state != IDLE). It is combinational from the state register.

Timing:
- Start sampled at edge E0. Results and done_o appear after edge E(size+1), i.e. 33 edges for size=32.
- hi_o/lo_o hold their previous values until that edge.
- done_o is registered and low in every other cycle.

Arithmetic:
- Multiply: 2*size-bit product. hi_o = upper half, lo_o = lower half.
- Signed multiply: negate the full 2*size product when the operand signs differ.
- Divide: lo_o = quotient, hi_o = remainder.
- Signed divide: quotient truncates toward zero; quotient negated when the signs differ; remainder takes the dividend's sign.
- Most-negative signed operand: its magnitude is handled as unsigned size bits. MULT of 0x80000000 must still give the correct result.
- Signed DIV 0x80000000 / -1 gives lo=0x80000000 (wraps), hi=0.

Boundary conditions:
- Divide by zero, signed or unsigned: lo_o = all ones, hi_o = dividend (raw src1_i). Takes the full normal latency with no early exit.
- start_i while busy_o=1: ignored. The in-flight operation and operands are unaffected.
- start_i in the same cycle done_o=1: accepted, since the state is IDLE.
- abort_i in RUN or FIN: next edge goes to IDLE with no done_o pulse; hi_o/lo_o keep their old values.
- abort_i in IDLE: no effect, and it overrides a simultaneous start_i.
- abort_i and rst_i together: reset wins.

Decomposition:
- Shared package / include holds:
  - op encodings MD_MULTU=2'b00, MD_MULT=2'b01, MD_DIVU=2'b10, MD_DIV=2'b11;
  - state encodings MD_IDLE, MD_RUN, MD_FIN;
  - counter width = clog2(size)+1.
- One natural sub-module: md_sign_fix. It is combinational: it takes magnitude results plus sign flags and produces signed HI/LO. It is instantiated once and used in FIN.
- The control FSM and datapath stay in mul_div_unit.

Test Plan:
1. MULTU 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done_o pulses exactly 33 edges after the start edge; busy_o high in every cycle in between.
2. MULT -3 (0xFFFFFFFD) * 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000 * 2 -> hi=0xFFFFFFFF, lo=0x00000000.
3. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
4. Start MULTU 5*6, pulse start_i again at cycle 10 with different operands -> hi=0, lo=30. The second request is ignored and only one done_o occurs. Then start_i during the done_o cycle -> accepted, busy_o high the next cycle.
5. Load hi/lo=0x1/0x2, start DIVU, assert abort_i at cycle 15 -> IDLE next edge, no done_o, hi=0x1/lo=0x2 unchanged.
6. Assert rst_i asynchronously (between edges) at cycle 20 of a MULT -> busy_o, done_o, hi_o, lo_o go 0 immediately, with no clock edge needed. After release, a new MULTU 3*4 gives lo=12.
